gate_result_checker: RTL



---
 rtl/gate_chk_pkg.sv | 36 +++
 rtl/gate_ref_model.sv | 18 +
 rtl/gate_result_checker.sv | 113 +++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate result checker: FSM states, res bit positions, expected-value function.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions inside the 7-bit res vector produced by the gate block
    localparam int RES_AND  = 0;
    localparam int RES_OR   = 1;
    localparam int RES_NAND = 2;
    localparam int RES_NOR  = 3;
    localparam int RES_XOR  = 4;
    localparam int RES_XNOR = 5;
    localparam int RES_NOT  = 6;
    localparam int RES_W    = 7;

    // What a correct gate block must produce for stimulus (a, b)
    function automatic logic [RES_W-1:0] gate_expect(input logic a, input logic b);
        logic [RES_W-1:0] e;
        e           = '0;
        e[RES_AND]  = a & b;
        e[RES_OR]   = a | b;
        e[RES_NAND] = ~(a & b);
        e[RES_NOR]  = ~(a | b);
        e[RES_XOR]  = a ^ b;
        e[RES_XNOR] = ~(a ^ b);
        e[RES_NOT]  = ~a;
        return e;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the gate block: expected outputs and per-bit mismatch mask.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows its inputs every cycle.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic             a,
    input  logic             b,
    input  logic [RES_W-1:0] res,
    output logic [RES_W-1:0] expected,
    output logic [RES_W-1:0] mask
);

    assign expected = gate_expect(a, b);
    // Unknown bits on a, b or res propagate into the mask as X, which is what gets captured
    assign mask     = expected ^ res;

endmodule

// File: rtl/gate_result_checker.sv
// Scoreboard for the two-input gate block: counts vectors/errors, captures first failure, gives verdict.
// Latency: counters and captures update on the accepting edge; done rises the cycle after the last beat.
// Backpressure: in_ready is high for the whole RUN state only, never a function of in_valid.
module gate_result_checker
    import gate_chk_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int N_VEC = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic [RES_W-1:0] res,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_seen,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [1:0]       first_fail_ab,
    output logic [RES_W-1:0] first_fail_mask
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_nxt;
    logic [RES_W-1:0] expected;
    logic [RES_W-1:0] mask;
    logic             mismatch;
    logic             beat;
    logic             run_start;

    gate_ref_model u_ref (
        .a        (a),
        .b        (b),
        .res      (res),
        .expected (expected),
        .mask     (mask)
    );

    // Case inequality so that any X/Z on the stimulus or the result counts as a failure
    assign mismatch  = (res !== expected);
    assign beat      = in_valid && in_ready;
    // start only has an effect outside RUN, so a run can never be restarted mid-flight
    assign run_start = start && (state != RUN);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: the beat that brings vec_cnt to N_VEC ends the run
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (beat && (vec_cnt == LAST_IDX)) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the registered state only
    always_comb begin
        in_ready = (state == RUN);
        done     = (state == DONE);
        pass     = (state == DONE) && (err_cnt == '0);
    end

    // Counters and first-failure capture; cleared on every run start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_cnt         <= '0;
            err_cnt         <= '0;
            fail_seen       <= 1'b0;
            first_fail_idx  <= '0;
            first_fail_ab   <= '0;
            first_fail_mask <= '0;
        end else if (run_start) begin
            vec_cnt         <= '0;
            err_cnt         <= '0;
            fail_seen       <= 1'b0;
            first_fail_idx  <= '0;
            first_fail_ab   <= '0;
            first_fail_mask <= '0;
        end else if (beat) begin
            vec_cnt <= vec_cnt + 1'b1;
            if (mismatch) begin
                if (err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (!fail_seen) begin
                    fail_seen       <= 1'b1;
                    first_fail_idx  <= vec_cnt;
                    first_fail_ab   <= {a, b};
                    first_fail_mask <= mask;
                end
            end
        end
    end

endmodule
